// File: rtl/sram_port_arbiter.sv
// Two-port arbiter for a single asynchronous 8-bit SRAM: round-robin grant,
// fixed-length ACCESS phase, one RECOVER cycle carrying the completion ack.
module sram_port_arbiter #(
   parameter int ADDR_W        = 21,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [7:0]        a_wdata,
   output logic              a_ack,

   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [7:0]        b_wdata,
   output logic              b_ack,

   output logic [7:0]        rdata,

   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dout,
   output logic              sram_oe,
   input  logic [7:0]        sram_din,
   output logic              sram_we_n,

   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2
   } state_t;

   localparam logic [3:0] COUNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [3:0]        count_reg, count_next;
   logic              we_reg, we_next;
   logic              port_b_reg, port_b_next;
   logic              last_b_reg, last_b_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [7:0]        dout_reg, dout_next;
   logic [7:0]        rdata_reg, rdata_next;

   logic              grant_a;
   logic              grant_b;

   // On a tie the port that was not served last wins.
   assign grant_a = a_req && (!b_req || last_b_reg);
   assign grant_b = b_req && (!a_req || !last_b_reg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         count_reg  <= 4'd0;
         we_reg     <= 1'b0;
         port_b_reg <= 1'b0;
         last_b_reg <= 1'b1;
         addr_reg   <= '0;
         dout_reg   <= 8'd0;
         rdata_reg  <= 8'd0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         we_reg     <= we_next;
         port_b_reg <= port_b_next;
         last_b_reg <= last_b_next;
         addr_reg   <= addr_next;
         dout_reg   <= dout_next;
         rdata_reg  <= rdata_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      we_next     = we_reg;
      port_b_next = port_b_reg;
      last_b_next = last_b_reg;
      addr_next   = addr_reg;
      dout_next   = dout_reg;
      rdata_next  = rdata_reg;

      case (state_reg)
         IDLE: begin
            if (grant_a) begin
               port_b_next = 1'b0;
               we_next     = a_we;
               addr_next   = a_addr;
               dout_next   = a_we ? a_wdata : dout_reg;
               count_next  = COUNT_LOAD;
               state_next  = ACCESS;
            end else if (grant_b) begin
               port_b_next = 1'b1;
               we_next     = b_we;
               addr_next   = b_addr;
               dout_next   = b_we ? b_wdata : dout_reg;
               count_next  = COUNT_LOAD;
               state_next  = ACCESS;
            end
         end

         ACCESS: begin
            if (count_reg == 4'd0) begin
               state_next = RECOVER;
               if (!we_reg) begin
                  rdata_next = sram_din;
               end
            end else begin
               count_next = count_reg - 4'd1;
            end
         end

         RECOVER: begin
            last_b_next = port_b_reg;
            state_next  = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Write data keeps driving the bus through RECOVER for hold time.
   assign sram_addr = addr_reg;
   assign sram_dout = dout_reg;
   assign sram_we_n = !((state_reg == ACCESS) && we_reg);
   assign sram_oe   = we_reg && ((state_reg == ACCESS) || (state_reg == RECOVER));
   assign a_ack     = (state_reg == RECOVER) && !port_b_reg;
   assign b_ack     = (state_reg == RECOVER) && port_b_reg;
   assign busy      = (state_reg != IDLE);
   assign rdata     = rdata_reg;

endmodule
